// File: rtl/hamming_pkg.sv
// Shared types, mode encodings and Hamming helpers for the serial SECDED codec.
// Helpers work on a fixed maximum width; callers zero-pad narrower codewords.
package hamming_pkg;

    localparam int unsigned MaxCw  = 64;
    localparam int unsigned MaxPar = 6;

    localparam logic ModeEnc = 1'b0;
    localparam logic ModeDec = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StEncShift,
        StDecShift,
        StDecEval
    } state_e;

    // Codeword position of data bit idx: the idx-th non-power-of-two position from 3 upward.
    function automatic int unsigned data_pos(input int unsigned idx);
        int unsigned pos;
        int unsigned seen;
        pos  = 0;
        seen = 0;
        for (int unsigned p = 1; p < MaxCw; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (seen == idx && pos == 0) begin
                    pos = p;
                end
                seen++;
            end
        end
        return pos;
    endfunction

    // XOR of the indices of all set bits; bit k equals the parity over positions with bit k set.
    function automatic logic [MaxPar-1:0] hamming_syndrome(input logic [MaxCw-1:0] cw);
        logic [MaxPar-1:0] s;
        s = '0;
        for (int p = 1; p < MaxCw; p++) begin
            if (cw[p]) begin
                s = s ^ MaxPar'(p);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/hamming_secded_core.sv
// Purely combinational SECDED datapath: encode a data word, and check/correct a codeword.
module hamming_secded_core
    import hamming_pkg::*;
#(
    parameter int unsigned DATA_W = 11,
    parameter int unsigned PAR_W  = 4,
    parameter int unsigned CW_W   = DATA_W + PAR_W + 1
) (
    input  logic [DATA_W-1:0] enc_data_i,
    output logic [CW_W-1:0]   enc_cw_o,
    input  logic [CW_W-1:0]   chk_cw_i,
    output logic [PAR_W-1:0]  chk_syndrome_o,
    output logic [DATA_W-1:0] chk_data_o,
    output logic              chk_corr_o,
    output logic              chk_uncorr_o
);

    logic [MaxCw-1:0]  enc_pad;
    logic [MaxPar-1:0] enc_syn;
    logic [MaxCw-1:0]  chk_pad;
    logic [MaxPar-1:0] chk_syn;
    logic              chk_par;
    logic [CW_W-1:0]   chk_fixed;

    // Syndrome of the data-only word gives the parity bits that cancel it to zero.
    always_comb begin
        enc_pad = '0;
        for (int i = 0; i < DATA_W; i++) begin
            enc_pad[data_pos(i)] = enc_data_i[i];
        end
        enc_syn = hamming_syndrome(enc_pad);
        for (int k = 0; k < PAR_W; k++) begin
            enc_pad[1 << k] = enc_syn[k];
        end
        enc_pad[0] = ^enc_pad;
        enc_cw_o   = enc_pad[CW_W-1:0];
    end

    always_comb begin
        chk_pad                 = '0;
        chk_pad[CW_W-1:0]       = chk_cw_i;
        chk_syn                 = hamming_syndrome(chk_pad);
        chk_par                 = ^chk_cw_i;
        chk_corr_o              = chk_par && (32'(chk_syn) < CW_W);
        chk_uncorr_o            = (!chk_par && (chk_syn != '0)) ||
                                  (chk_par && (32'(chk_syn) >= CW_W));
        chk_syndrome_o          = chk_syn[PAR_W-1:0];
        chk_fixed               = chk_cw_i;
        for (int unsigned p = 0; p < CW_W; p++) begin
            if (chk_corr_o && (32'(chk_syn) == p)) begin
                chk_fixed[p] = ~chk_cw_i[p];
            end
        end
        for (int i = 0; i < DATA_W; i++) begin
            chk_data_o[i] = chk_fixed[data_pos(i)];
        end
    end

endmodule

// File: rtl/hamming_secded_serial_codec.sv
// Serial SECDED codec: one FSM shifts encoded codewords out or shifts codewords in for checking,
// with saturating corrected/uncorrectable error counters.
module hamming_secded_serial_codec
    import hamming_pkg::*;
#(
    parameter int unsigned DATA_W = 11,
    parameter int unsigned PAR_W  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              mode_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic              bit_in_i,
    input  logic              bit_in_valid_i,
    input  logic              cnt_clr_i,
    output logic              busy_o,
    output logic              bit_out_o,
    output logic              bit_out_valid_o,
    output logic [DATA_W-1:0] data_out_o,
    output logic [PAR_W-1:0]  syndrome_o,
    output logic              err_corr_o,
    output logic              err_uncorr_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  corr_cnt_o,
    output logic [CNT_W-1:0]  uncorr_cnt_o
);

    localparam int unsigned CW_W    = DATA_W + PAR_W + 1;
    localparam int unsigned BitCntW = $clog2(CW_W);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(CW_W - 1);

    if (2 ** PAR_W < DATA_W + PAR_W + 1) begin : g_bad_par_w
        $error("PAR_W too small for DATA_W");
    end
    if (CW_W > MaxCw) begin : g_bad_cw_w
        $error("codeword wider than hamming_pkg::MaxCw");
    end

    state_e              state_q, state_d;
    logic [CW_W-1:0]     shreg_q, shreg_d;
    logic [BitCntW-1:0]  bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic [PAR_W-1:0]    syndrome_q, syndrome_d;
    logic                err_corr_q, err_corr_d;
    logic                err_uncorr_q, err_uncorr_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]    uncorr_cnt_q, uncorr_cnt_d;

    logic [CW_W-1:0]     enc_cw;
    logic [PAR_W-1:0]    chk_syndrome;
    logic [DATA_W-1:0]   chk_data;
    logic                chk_corr;
    logic                chk_uncorr;

    hamming_secded_core #(
        .DATA_W (DATA_W),
        .PAR_W  (PAR_W),
        .CW_W   (CW_W)
    ) u_core (
        .enc_data_i     (data_in_i),
        .enc_cw_o       (enc_cw),
        .chk_cw_i       (shreg_q),
        .chk_syndrome_o (chk_syndrome),
        .chk_data_o     (chk_data),
        .chk_corr_o     (chk_corr),
        .chk_uncorr_o   (chk_uncorr)
    );

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        data_out_d   = data_out_q;
        syndrome_d   = syndrome_q;
        err_corr_d   = err_corr_q;
        err_uncorr_d = err_uncorr_q;
        done_d       = 1'b0;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    bitcnt_d = '0;
                    if (mode_i == ModeEnc) begin
                        shreg_d = enc_cw;
                        state_d = StEncShift;
                    end else begin
                        state_d = StDecShift;
                    end
                end
            end
            StEncShift: begin
                shreg_d  = shreg_q >> 1;
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == LastBit) begin
                    state_d = StIdle;
                end
            end
            StDecShift: begin
                if (bit_in_valid_i) begin
                    shreg_d[bitcnt_q] = bit_in_i;
                    bitcnt_d          = bitcnt_q + 1'b1;
                    if (bitcnt_q == LastBit) begin
                        state_d = StDecEval;
                    end
                end
            end
            StDecEval: begin
                data_out_d   = chk_data;
                syndrome_d   = chk_syndrome;
                err_corr_d   = chk_corr;
                err_uncorr_d = chk_uncorr;
                done_d       = 1'b1;
                state_d      = StIdle;
                if (chk_corr && corr_cnt_q != '1) begin
                    corr_cnt_d = corr_cnt_q + 1'b1;
                end
                if (chk_uncorr && uncorr_cnt_q != '1) begin
                    uncorr_cnt_d = uncorr_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A clear in the same cycle as an increment takes priority.
        if (cnt_clr_i) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            data_out_q   <= '0;
            syndrome_q   <= '0;
            err_corr_q   <= 1'b0;
            err_uncorr_q <= 1'b0;
            done_q       <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            data_out_q   <= data_out_d;
            syndrome_q   <= syndrome_d;
            err_corr_q   <= err_corr_d;
            err_uncorr_q <= err_uncorr_d;
            done_q       <= done_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    always_comb begin
        busy_o          = (state_q != StIdle);
        bit_out_valid_o = (state_q == StEncShift);
        bit_out_o       = (state_q == StEncShift) && shreg_q[0];
        // Encode done rides with the last serial bit; decode done comes from the eval register.
        done_o          = done_q || ((state_q == StEncShift) && (bitcnt_q == LastBit));
        data_out_o      = data_out_q;
        syndrome_o      = syndrome_q;
        err_corr_o      = err_corr_q;
        err_uncorr_o    = err_uncorr_q;
        corr_cnt_o      = corr_cnt_q;
        uncorr_cnt_o    = uncorr_cnt_q;
    end

endmodule

// File: tb/tb_hamming_secded_serial_codec.sv
// Directed bench for the serial SECDED codec with an independent encode/decode model.
module tb_hamming_secded_serial_codec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic        start = 1'b0;
    logic [10:0] data_in = '0;
    logic        bit_in = 1'b0;
    logic        bit_in_valid = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        busy, bit_out, bit_out_valid, err_corr, err_uncorr, done;
    logic [10:0] data_out;
    logic [3:0]  syndrome;
    logic [7:0]  corr_cnt, uncorr_cnt;

    typedef struct packed {
        logic [10:0] data;
        logic [3:0]  syn;
        logic        corr;
        logic        uncorr;
    } dec_exp_t;

    dec_exp_t    dec_q[$];
    logic [15:0] enc_q[$];
    int errors = 0;
    int checks = 0;
    int exp_corr_cnt = 0;
    int exp_uncorr_cnt = 0;

    hamming_secded_serial_codec dut (
        .clk_i           (clk),
        .rst_n           (rst_n),
        .mode_i          (mode),
        .start_i         (start),
        .data_in_i       (data_in),
        .bit_in_i        (bit_in),
        .bit_in_valid_i  (bit_in_valid),
        .cnt_clr_i       (cnt_clr),
        .busy_o          (busy),
        .bit_out_o       (bit_out),
        .bit_out_valid_o (bit_out_valid),
        .data_out_o      (data_out),
        .syndrome_o      (syndrome),
        .err_corr_o      (err_corr),
        .err_uncorr_o    (err_uncorr),
        .done_o          (done),
        .corr_cnt_o      (corr_cnt),
        .uncorr_cnt_o    (uncorr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc_model(input logic [10:0] d);
        logic [15:0] cw;
        logic        b;
        int          j;
        cw = '0;
        j  = 0;
        for (int p = 1; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            b = 1'b0;
            for (int p = 1; p < 16; p++) begin
                if (((p >> k) & 1) == 1) b = b ^ cw[p];
            end
            cw[1 << k] = b;
        end
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    function automatic dec_exp_t dec_model(input logic [15:0] cw);
        dec_exp_t    e;
        logic [15:0] fixed;
        logic [3:0]  s;
        int          j;
        s = '0;
        for (int p = 1; p < 16; p++) begin
            if (cw[p]) s = s ^ 4'(p);
        end
        fixed    = cw;
        e.corr   = 1'b0;
        e.uncorr = 1'b0;
        if (^cw) begin
            fixed[s] = ~fixed[s];
            e.corr   = 1'b1;
        end else if (s != 0) begin
            e.uncorr = 1'b1;
        end
        e.syn = s;
        j     = 0;
        for (int p = 1; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                e.data[j] = fixed[p];
                j++;
            end
        end
        return e;
    endfunction

    task automatic run_encode(input logic [10:0] d, input logic [15:0] exp_cw);
        logic [15:0] got, want;
        int first, nvalid, done_idx, ndone;
        enc_q.push_back(exp_cw);
        got = '0; first = -1; nvalid = 0; done_idx = -1; ndone = 0;
        @(negedge clk); start = 1'b1; mode = 1'b0; data_in = d;
        @(negedge clk); start = 1'b0; data_in = ~d;
        for (int c = 0; c < 20; c++) begin
            if (bit_out_valid) begin
                if (first < 0) first = c;
                if (nvalid < 16) got[nvalid] = bit_out;
                if (done) done_idx = c;
                nvalid++;
            end
            if (done) ndone++;
            start = (c == 5); // ignored while busy
            mode  = (c == 5);
            @(negedge clk);
        end
        start = 1'b0; mode = 1'b0;
        want = enc_q.pop_front();
        check("enc_first_valid", first, 0);
        check("enc_valid_cycles", nvalid, 16);
        check("enc_codeword", got, want);
        check("enc_done_on_last", done_idx, 15);
        check("enc_done_count", ndone, 1);
        check("enc_idle_after", busy, 0);
    endtask

    task automatic run_decode(input logic [15:0] cw, input bit gaps, input bit clr);
        dec_exp_t e, want;
        int lat;
        e = dec_model(cw);
        dec_q.push_back(e);
        if (clr) begin
            exp_corr_cnt = 0; exp_uncorr_cnt = 0;
        end else begin
            if (e.corr && exp_corr_cnt < 255) exp_corr_cnt++;
            if (e.uncorr && exp_uncorr_cnt < 255) exp_uncorr_cnt++;
        end
        cnt_clr = clr;
        @(negedge clk); start = 1'b1; mode = 1'b1;
        @(negedge clk); start = 1'b0; mode = 1'b0;
        check("dec_busy", busy, 1);
        for (int i = 0; i < 16; i++) begin
            if (gaps && (i % 4 == 2)) begin
                bit_in_valid = 1'b0; bit_in = ~cw[i]; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            bit_in = cw[i]; bit_in_valid = 1'b1;
            @(negedge clk);
        end
        bit_in_valid = 1'b0; bit_in = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 6) begin
            @(negedge clk);
            lat++;
        end
        check("dec_done_latency", lat, 1);
        want = dec_q.pop_front();
        check("dec_data_out", data_out, want.data);
        check("dec_syndrome", syndrome, want.syn);
        check("dec_err_corr", err_corr, want.corr);
        check("dec_err_uncorr", err_uncorr, want.uncorr);
        check("dec_corr_cnt", corr_cnt, exp_corr_cnt);
        check("dec_uncorr_cnt", uncorr_cnt, exp_uncorr_cnt);
        @(negedge clk);
        cnt_clr = 1'b0;
        check("dec_done_pulse", done, 0);
        check("dec_idle_after", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_bit_out"}, bit_out, 0);
        check({tag, "_bit_out_valid"}, bit_out_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_syndrome"}, syndrome, 0);
        check({tag, "_err_corr"}, err_corr, 0);
        check({tag, "_err_uncorr"}, err_uncorr, 0);
        check({tag, "_corr_cnt"}, corr_cnt, 0);
        check({tag, "_uncorr_cnt"}, uncorr_cnt, 0);
    endtask

    initial begin
        int ndone;
        #12;
        check_all_zero("reset");
        @(negedge clk); rst_n = 1'b1;

        run_encode(11'h7FF, 16'hFFFF);
        run_encode(11'h001, 16'h000F);
        run_encode(11'h555, enc_model(11'h555));

        run_decode(16'hFFDF, 1'b0, 1'b0);
        run_decode(16'hFFD7, 1'b0, 1'b0);
        run_decode(16'hFFFE, 1'b1, 1'b0);
        run_decode(enc_model(11'h2A5) ^ 16'h1000, 1'b1, 1'b0);

        // Abort a decode part-way with reset.
        @(negedge clk); start = 1'b1; mode = 1'b1;
        @(negedge clk); start = 1'b0; mode = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bit_in = 1'b1; bit_in_valid = 1'b1;
            @(negedge clk);
        end
        bit_in_valid = 1'b0; bit_in = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_corr_cnt = 0; exp_uncorr_cnt = 0;
        check_all_zero("abort");
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_idle", busy, 0);

        run_decode(16'h000F, 1'b0, 1'b0);

        for (int n = 0; n < 256; n++) run_decode(16'hFFDF, 1'b0, 1'b0);
        check("corr_cnt_saturated", corr_cnt, 255);

        run_decode(16'hFFD7, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hamming_secded_serial_codec.md
Name: hamming_secded_serial_codec

Overview:
Parametrised serial Hamming SECDED codec, successor to the fixed 11-bit SEC encoder/decoder pair. A single FSM handles both directions. Encode mode loads a parallel data word and shifts the codeword out serially. Decode mode shifts a codeword in serially, then corrects single errors and flags double errors. Mode is sampled synchronously at start, not toggled from an input-pin clock. Sits behind the chip top pin mux; saturating error counters feed a status readout.

Parameters:
DATA_W, 11, data word width.
PAR_W, 4, Hamming parity bits; must satisfy 2**PAR_W >= DATA_W+PAR_W+1 (elaboration-time check).
CW_W, DATA_W+PAR_W+1, codeword width (derived; includes overall parity bit).
CNT_W, 8, error counter width.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
mode  in  1  0=encode, 1=decode; sampled only when start accepted.
start  in  1  begin operation; accepted only in IDLE.
data_in  in  DATA_W  encode payload; captured on accepted start.
bit_in  in  1  decode serial codeword bit, bit 0 first.
bit_in_valid  in  1  qualifies bit_in.
cnt_clr  in  1  synchronous clear of both error counters.
busy  out  1  high in any state other than IDLE.
bit_out  out  1  encode serial codeword bit, bit 0 first.
bit_out_valid  out  1  qualifies bit_out.
data_out  out  DATA_W  decoded (corrected) data, held until next done.
syndrome  out  PAR_W  last decode syndrome.
err_corr  out  1  last decode had a corrected single error.
err_uncorr  out  1  last decode had an uncorrectable error.
done  out  1  one-cycle pulse at end of an encode or decode.
corr_cnt  out  CNT_W  saturating count of corrected errors.
uncorr_cnt  out  CNT_W  saturating count of uncorrectable errors.

Behaviour:
- Reset: FSM=IDLE; every output 0; shift register, bit counter and counters 0.
- Codeword layout: bit 0 = overall even parity across all CW_W bits. Positions 1..CW_W-1 use classic Hamming placement: parity at powers of 2, data LSB-first in remaining positions ascending. Parity bit 2^k is the XOR of positions with bit k set.
- States: IDLE, ENC_SHIFT, DEC_SHIFT, DEC_EVAL.
- IDLE + start, mode=0: codeword computed combinationally from data_in into the shift register; go to ENC_SHIFT.
- IDLE + start, mode=1: clear the bit counter; go to DEC_SHIFT.
- start when not IDLE is ignored. mode changes outside the start cycle are ignored.
- ENC_SHIFT: bit_out_valid=1 for exactly CW_W consecutive cycles starting the cycle after start, emitting bit 0 first. done pulses together with the last bit; return to IDLE.
- DEC_SHIFT: each cycle with bit_in_valid=1 stores bit_in at index = counter and increments the counter. Gaps (valid=0) are allowed. After the CW_W-th bit, go to DEC_EVAL.
- DEC_EVAL (1 cycle): compute syndrome s and overall parity p, register results, pulse done, return to IDLE.
  - s=0, p=0: clean; both flags 0.
  - p=1, s<CW_W: flip bit s (s=0 means the overall parity bit itself); err_corr=1.
  - p=0, s!=0: double error; err_uncorr=1; data_out is the raw uncorrected data.
  - p=1, s>=CW_W: err_uncorr=1.
- Decode latency: done is asserted one cycle after the clock that accepts the final bit.
- Counters: +1 on the done cycle for the matching flag; saturate at all-ones. If cnt_clr coincides with an increment, clear wins.
- Asynchronous reset mid-operation aborts immediately. Partial codewords are discarded and no done is issued.

Decomposition:
- Package hamming_pkg: function returning the position-index map for data bits; function computing the Hamming parity vector; mode encoding constants ENC=0, DEC=1; FSM state enum.
- One natural sub-module, hamming_secded_core: purely combinational encode (data→codeword) and check (codeword→syndrome, parity, corrected data). The FSM wrapper owns all sequential logic.

Test Plan:
- Encode data_in=11'h7FF -> 16 bit_out_valid cycles, all bit_out=1 (codeword 16'hFFFF); done on cycle 16.
- Encode data_in=11'h001 -> serial codeword 16'h000F, LSB first.
- Decode 16'hFFDF (bit 5 flipped) -> data_out=11'h7FF, syndrome=5, err_corr=1, corr_cnt=1.
- Decode 16'hFFD7 (bits 3,5 flipped) -> syndrome=6, err_uncorr=1, err_corr=0, uncorr_cnt=1.
- Decode 16'hFFFE (bit 0 flipped) with bit_in_valid gaps -> data_out=11'h7FF, syndrome=0, err_corr=1. Start pulses during busy are ignored.
- Assert rst_n low after 7 decode bits -> all outputs 0, no done. A new clean decode of 16'h000F -> data_out=11'h001, both flags 0.
